// File: rtl/scomp_pkg.sv
// scomp_pkg: shared constants and encodings for the serial two's-complement stream.
//   mode_e         MODE_PASS (copy) / MODE_NEG (negate)
//   lane_state_e   SEEK (no 1 seen yet in this word) / INV (invert remaining bits)
//   frame_state_e  framing state of the shared bit counter
//   W_MIN..N_MAX   legal parameter bounds
package scomp_pkg;

    localparam int unsigned W_MIN = 2;
    localparam int unsigned W_MAX = 32;
    localparam int unsigned N_MIN = 1;
    localparam int unsigned N_MAX = 16;

    typedef enum logic {
        MODE_PASS = 1'b0,
        MODE_NEG  = 1'b1
    } mode_e;

    typedef enum logic {
        SEEK = 1'b0,
        INV  = 1'b1
    } lane_state_e;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_RUN  = 1'b1
    } frame_state_e;

endpackage

// File: rtl/scomp_stream_if.sv
// scomp_stream_if: serial stream bus for scomp_stream.
//   i/i_vld/sof/mode : producer -> block (one data bit per channel, LSB first)
//   y/y_vld/eow      : block -> consumer (registered result bits)
//   ovf              : per-channel negation overflow, only with SCOMP_OVF_EN
interface scomp_stream_if #(
    parameter int unsigned N = 2
);
    logic [N-1:0] i;
    logic         i_vld;
    logic         sof;
    logic         mode;
    logic [N-1:0] y;
    logic         y_vld;
    logic         eow;
`ifdef SCOMP_OVF_EN
    logic [N-1:0] ovf;
`endif

    modport master (
        output i, i_vld, sof, mode,
`ifdef SCOMP_OVF_EN
        input  ovf,
`endif
        input  y, y_vld, eow
    );

    modport slave (
        input  i, i_vld, sof, mode,
`ifdef SCOMP_OVF_EN
        output ovf,
`endif
        output y, y_vld, eow
    );
endinterface

// File: rtl/scomp_lane.sv
// scomp_lane: one serial channel of the two's-complement stream.
// Optional feature macro: SCOMP_OVF_EN (adds the ovf output).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   acc        : a bit is accepted this cycle
//   start      : accepted bit is bit 0 of a word (lane restarts in SEEK)
//   last       : accepted bit is bit W-1 of a word (lane returns to SEEK)
//   neg        : effective mode for this bit (1 = negate)
//   d          : serial input bit
//   y          : registered result bit (0 when nothing was accepted)
//   ovf        : registered pulse on the last bit of a most-negative word
import scomp_pkg::*;

module scomp_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic acc,
    input  logic start,
    input  logic last,
    input  logic neg,
    input  logic d,
`ifdef SCOMP_OVF_EN
    output logic ovf,
`endif
    output logic y
);

    lane_state_e state_q, state_d, state_eff_c;
    logic        y_d;
    logic        ovf_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEEK;
            y       <= 1'b0;
        end else begin
            state_q <= state_d;
            y       <= y_d;
        end
    end

    // Copy bits until the first 1 has passed, invert afterwards
    always_comb begin
        state_d     = state_q;
        y_d         = 1'b0;
        ovf_d       = 1'b0;
        state_eff_c = start ? SEEK : state_q;
        if (acc) begin
            y_d = (neg && state_eff_c == INV) ? ~d : d;
            if (last) begin
                state_d = SEEK;
            end else if (neg && state_eff_c == SEEK && d) begin
                state_d = INV;
            end else begin
                state_d = state_eff_c;
            end
            // Still in SEEK at the top bit with a 1: lower bits were all zero
            ovf_d = last && neg && (state_eff_c == SEEK) && d;
        end
    end

`ifdef SCOMP_OVF_EN
    // Overflow flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_d;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf_d;
`endif

endmodule

// File: rtl/scomp_stream.sv
// scomp_stream: N-channel bit-serial two's-complement negator (or pass-through).
// Optional feature macro: SCOMP_OVF_EN (per-channel most-negative overflow flag).
// Ports:
//   t_clk : clock, rising edge
//   r     : async active-low reset
//   bus   : scomp_stream_if.slave (i, i_vld, sof, mode in; y, y_vld, eow, ovf out)
// The shared bit counter and framing live here; per-channel state lives in scomp_lane.
import scomp_pkg::*;

module scomp_stream #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 2
) (
    input  logic           t_clk,
    input  logic           r,
    scomp_stream_if.slave  bus
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    frame_state_e    fsm_q, fsm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    mode_e           mode_q, mode_d;
    logic            y_vld_q, eow_q;
    logic            acc_c, start_c, last_c, neg_c;
    logic [N-1:0]    lane_y;

    // Framing state, counter and latched mode
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            fsm_q   <= FR_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_PASS;
            y_vld_q <= 1'b0;
            eow_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            y_vld_q <= acc_c;
            eow_q   <= last_c;
        end
    end

    // Accept rules: sof always starts a word; other bits only inside a word
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        acc_c   = 1'b0;
        start_c = 1'b0;
        last_c  = 1'b0;
        if (bus.i_vld) begin
            if (bus.sof) begin
                acc_c   = 1'b1;
                start_c = 1'b1;
                fsm_d   = FR_RUN;
                cnt_d   = CW'(1);
                mode_d  = mode_e'(bus.mode);
            end else if (fsm_q == FR_RUN) begin
                acc_c = 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    last_c = 1'b1;
                    fsm_d  = FR_IDLE;
                    cnt_d  = '0;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
        end
    end

    // Bit 0 uses the mode presented with sof; later bits use the latched one
    assign neg_c = start_c ? bus.mode : (mode_q == MODE_NEG);

    for (genvar c = 0; c < N; c++) begin : g_lane
        scomp_lane u_lane (
            .clk   (t_clk),
            .rst_n (r),
            .acc   (acc_c),
            .start (start_c),
            .last  (last_c),
            .neg   (neg_c),
            .d     (bus.i[c]),
`ifdef SCOMP_OVF_EN
            .ovf   (bus.ovf[c]),
`endif
            .y     (lane_y[c])
        );
    end

    assign bus.y     = lane_y;
    assign bus.y_vld = y_vld_q;
    assign bus.eow   = eow_q;

endmodule

// File: doc/scomp_stream.md
SCOMP_STREAM -- requirements
Module: scomp_stream

Interface
REQ-001 Parameter W, default 8, is the word length in bits; legal range is 2..32.
REQ-002 Parameter N, default 2, is the number of independent serial channels; legal range is 1..16.
REQ-003 Port t_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port r, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port i, input, N bits: serial data, one bit per channel, LSB first.
REQ-006 Port i_vld, input, 1 bit: bit strobe common to all channels; i is sampled only when i_vld=1.
REQ-007 Port sof, input, 1 bit: start of frame; qualified by i_vld; marks bit 0 of a new word.
REQ-008 Port mode, input, 1 bit: MODE_PASS=0 (copy input), MODE_NEG=1 (two's complement).
REQ-009 Port y, output, N bits: serial result, registered.
REQ-010 Port y_vld, output, 1 bit: y carries a valid result bit.
REQ-011 Port eow, output, 1 bit: y carries bit W-1 of a word.
REQ-012 Port ovf, output, N bits: per-channel negation overflow, present only under SCOMP_OVF_EN.

Function
REQ-013 Each channel lane SHALL hold a state of either SEEK (no 1 seen yet in the current word) or INV.
REQ-014 In MODE_NEG, a lane in SEEK SHALL output the input bit; a lane in INV SHALL output the inverted input bit.
REQ-015 A lane in SEEK that accepts i=1 SHALL move to INV after that bit.
REQ-016 In MODE_PASS, y SHALL equal i and the lane SHALL stay in SEEK.
REQ-017 Latency SHALL be one cycle: a bit accepted at edge k SHALL appear on y with y_vld=1 after edge k; y_vld SHALL be 0 on cycles with no accepted bit.
REQ-018 The shared bit counter SHALL run 0..W-1 and is framed: it is idle from reset until a bit is accepted with sof=1.
REQ-019 While the counter is idle, bits with i_vld=1 and sof=0 SHALL be ignored (y_vld stays 0).
REQ-020 A bit accepted with sof=1 SHALL be treated as bit 0: every lane restarts in SEEK for that bit and the counter is set to 0, including when sof arrives mid-word (the partial word is abandoned, no eow).
REQ-021 After bit W-1 is accepted, eow SHALL pulse with that bit; the counter SHALL return to idle and every lane to SEEK.
REQ-022 sof with i_vld=0 SHALL be ignored. Gaps in i_vld SHALL hold all state.
REQ-023 mode SHALL be sampled at sof and held for the whole word; changes mid-word have no effect until the next sof.
REQ-024 The output y for an all-zero word SHALL be all zeros.

Reset
REQ-025 With r=0: y=0, y_vld=0, eow=0, ovf=0, counter idle, all lanes SEEK, latched mode=MODE_PASS; this applies immediately, regardless of the clock.
REQ-026 Reset mid-word SHALL discard the word; after release, output SHALL resume only after the next sof.

Configuration
REQ-027 With macro SCOMP_OVF_EN defined, ovf[c] SHALL pulse together with eow when mode is MODE_NEG and channel c's word is 100...0 (most negative value, bits 0..W-2 zero and bit W-1 one). For that word, y passes the value through unchanged.
REQ-028 Without SCOMP_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package scomp_pkg SHALL hold the mode constants MODE_PASS/MODE_NEG, the lane state encoding SEEK/INV, and the parameter bounds.
REQ-030 A sub-module scomp_lane SHALL implement one channel: state, output register and overflow tracking. It is instantiated N times. The bit counter and framing logic stay in scomp_stream.

Verification (W=8, N=2)
REQ-031 MODE_NEG, ch0=0x06, ch1=0x01, contiguous i_vld -> ch0 y=0xFA, ch1 y=0xFF; eow on the 8th output bit; y_vld held for 8 cycles.
REQ-032 MODE_NEG, ch0=0x00, ch1=0x80 with SCOMP_OVF_EN -> y0=0x00 with ovf[0]=0; y1=0x80 with ovf[1]=1 coincident with eow.
REQ-033 MODE_PASS, ch0=0xA5 with i_vld gaps of 1-3 cycles -> y0=0xA5; y_vld only on accepted bits; lane state stays SEEK.
REQ-034 sof reasserted at bit 4 of a word, then a new word 0x03 in MODE_NEG -> no eow for the abandoned word; y0=0xFD.
REQ-035 r=0 pulsed asynchronously between edges at bit 3 -> all outputs 0 at once; bits before the next sof are ignored; the next word 0x02 gives y=0xFE.
REQ-036 mode toggled mid-word -> the word completes in the mode latched at sof.
